// File: rtl/fetch_prefetch_unit.sv
// fetch_prefetch_unit: instruction memory, redirectable PC and FIFO prefetch queue for the IF stage.
// Optional halt-word detection is enabled with `define FETCH_HALT_DETECT_EN.
module fetch_prefetch_unit #(
    parameter int DATA_WIDTH  = 32,
    parameter int IMEM_DEPTH  = 256,
    parameter int QUEUE_DEPTH = 4
) (
    input  logic                               i_clock,
    input  logic                               i_reset,
    input  logic                               i_loading,
    input  logic [DATA_WIDTH-1:0]              i_address,
    input  logic [DATA_WIDTH-1:0]              i_instruccion,
    input  logic [1:0]                         i_select,
    input  logic [DATA_WIDTH-1:0]              i_pc_branch,
    input  logic [DATA_WIDTH-1:0]              i_pc_jump,
    input  logic                               i_stall,
    output logic [DATA_WIDTH-1:0]              o_instruccion,
    output logic [DATA_WIDTH-1:0]              o_pc_incr,
    output logic                               o_valid,
    output logic [$clog2(QUEUE_DEPTH+1)-1:0]   o_count,
    output logic [DATA_WIDTH-1:0]              o_pc,
    output logic                               o_halted
);
    localparam int AW = $clog2(IMEM_DEPTH);
    localparam int PW = $clog2(QUEUE_DEPTH);
    localparam int CW = $clog2(QUEUE_DEPTH+1);

    logic [DATA_WIDTH-1:0] imem    [IMEM_DEPTH];
    logic [DATA_WIDTH-1:0] q_instr [QUEUE_DEPTH];
    logic [DATA_WIDTH-1:0] q_pcinc [QUEUE_DEPTH];
    logic [PW-1:0]         rd_ptr, wr_ptr;
    logic [CW-1:0]         count;
    logic [DATA_WIDTH-1:0] pc, pc_incr, fetch_word;
    logic                  halted, pop, push, redirect, unused;

    assign fetch_word = imem[pc[AW+1:2]];
    assign pc_incr    = pc + DATA_WIDTH'(4);
    assign redirect   = i_select[0] ^ i_select[1];
    assign pop        = o_valid && !i_stall;
    // a full queue still accepts a new entry when the head leaves in the same cycle
    assign push       = !i_loading && i_select == 2'b00 && !halted && (count < CW'(QUEUE_DEPTH) || pop);
    assign unused     = ^{i_address[DATA_WIDTH-1:AW+2], i_address[1:0], i_pc_branch[1:0], i_pc_jump[1:0]};

    always_ff @(posedge i_clock)
        if (!i_reset && i_loading)
            imem[i_address[AW+1:2]] <= i_instruccion;

    always_ff @(posedge i_clock)
        if (!i_reset && !i_loading && !redirect && push) begin
            q_instr[wr_ptr] <= fetch_word;
            q_pcinc[wr_ptr] <= pc_incr;
        end

    always_ff @(posedge i_clock) begin
        if (i_reset || i_loading) begin
            pc     <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (redirect) begin
            pc     <= {i_select[0] ? i_pc_branch[DATA_WIDTH-1:2] : i_pc_jump[DATA_WIDTH-1:2], 2'b00};
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
                pc     <= pc_incr;
            end
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

`ifdef FETCH_HALT_DETECT_EN
    always_ff @(posedge i_clock)
        if (i_reset || i_loading || redirect)
            halted <= 1'b0;
        else if (push && &fetch_word)
            halted <= 1'b1;
`else
    assign halted = 1'b0;
`endif

    assign o_valid       = count != '0;
    assign o_instruccion = o_valid ? q_instr[rd_ptr] : '0;
    assign o_pc_incr     = o_valid ? q_pcinc[rd_ptr] : '0;
    assign o_count       = count;
    assign o_pc          = pc;
    assign o_halted      = halted;
endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// tb_fetch_prefetch_unit: table-driven directed vectors plus hand sequences for fetch_prefetch_unit.
module tb_fetch_prefetch_unit;
    logic        clk = 1'b0;
    logic        i_reset, i_loading, i_stall;
    logic [31:0] i_address, i_instruccion, i_pc_branch, i_pc_jump;
    logic [1:0]  i_select;
    logic [31:0] o_instruccion, o_pc_incr, o_pc;
    logic        o_valid, o_halted;
    logic [2:0]  o_count;
    int          checks = 0, failures = 0;
    logic [31:0] m [32];

    typedef struct {
        logic        rst, ld;
        logic [1:0]  sel;
        logic [31:0] tgt;
        logic        stall;
        int          ek;
        int          ecount;
        logic [31:0] epc;
    } vec_t;
    vec_t tbl [$];

    fetch_prefetch_unit dut (
        .i_clock(clk), .i_reset(i_reset), .i_loading(i_loading), .i_address(i_address),
        .i_instruccion(i_instruccion), .i_select(i_select), .i_pc_branch(i_pc_branch),
        .i_pc_jump(i_pc_jump), .i_stall(i_stall), .o_instruccion(o_instruccion),
        .o_pc_incr(o_pc_incr), .o_valid(o_valid), .o_count(o_count), .o_pc(o_pc), .o_halted(o_halted)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", nm, act, exp);
        end
    endtask

    function automatic vec_t v(input logic rst, input logic ld, input logic [1:0] sel, input logic [31:0] tgt,
                               input logic stall, input int ek, input int ecount, input logic [31:0] epc);
        vec_t r;
        r.rst = rst; r.ld = ld; r.sel = sel; r.tgt = tgt; r.stall = stall;
        r.ek = ek; r.ecount = ecount; r.epc = epc;
        return r;
    endfunction

    task automatic load(input logic [31:0] a, input logic [31:0] d);
        i_loading = 1'b1; i_address = a; i_instruccion = d;
        step();
        i_loading = 1'b0;
    endtask

    initial begin
        i_reset = 1'b1; i_loading = 1'b0; i_stall = 1'b0; i_select = 2'b00;
        i_address = '0; i_instruccion = '0; i_pc_branch = '0; i_pc_jump = '0;
        step(); step();
        chk("rst.pc", o_pc, 0);
        chk("rst.count", 32'(o_count), 0);
        chk("rst.valid", 32'(o_valid), 0);
        chk("rst.instr", o_instruccion, 0);
        chk("rst.pcinc", o_pc_incr, 0);
        chk("rst.halted", 32'(o_halted), 0);
        i_reset = 1'b0;

        m[0] = 32'h00221821; m[1] = 32'h00000000; m[2] = 32'h8C430004; m[3] = 32'h10000002;
        for (int k = 4; k < 32; k++) m[k] = 32'hA0000000 | 32'(k);
        for (int k = 0; k < 32; k++) load(32'(4 * k), m[k]);
        load(32'h410, 32'h12345678);
        m[4] = 32'h12345678;
        load(32'h3FC, 32'hCAFEF00D);
        chk("load.pc", o_pc, 0);
        chk("load.count", 32'(o_count), 0);

        tbl.push_back(v(0,0,0,0,0,  0,1,32'd4));
        tbl.push_back(v(0,0,0,0,0,  1,1,32'd8));
        tbl.push_back(v(0,0,0,0,0,  2,1,32'd12));
        tbl.push_back(v(0,0,0,0,0,  3,1,32'd16));
        tbl.push_back(v(0,1,0,0,0, -1,0,32'd0));
        tbl.push_back(v(1,0,0,0,0, -1,0,32'd0));
        tbl.push_back(v(0,0,0,0,1,  0,1,32'd4));
        tbl.push_back(v(0,0,0,0,1,  0,2,32'd8));
        tbl.push_back(v(0,0,0,0,1,  0,3,32'd12));
        tbl.push_back(v(0,0,0,0,1,  0,4,32'd16));
        tbl.push_back(v(0,0,0,0,1,  0,4,32'd16));
        tbl.push_back(v(0,0,0,0,1,  0,4,32'd16));
        tbl.push_back(v(0,0,0,0,0,  1,4,32'd20));
        tbl.push_back(v(0,0,0,0,0,  2,4,32'd24));
        tbl.push_back(v(0,0,0,0,0,  3,4,32'd28));
        tbl.push_back(v(0,0,0,0,0,  4,4,32'd32));
        tbl.push_back(v(1,0,0,0,0, -1,0,32'd0));
        tbl.push_back(v(0,0,0,0,1,  0,1,32'd4));
        tbl.push_back(v(0,0,0,0,1,  0,2,32'd8));
        tbl.push_back(v(0,0,0,0,1,  0,3,32'd12));
        tbl.push_back(v(0,0,1,32'h23,1, -1,0,32'h20));
        tbl.push_back(v(0,0,0,0,1,  8,1,32'h24));
        tbl.push_back(v(0,0,0,0,1,  8,2,32'h28));
        tbl.push_back(v(0,0,3,0,0,  9,1,32'h28));
        tbl.push_back(v(0,0,3,0,0, -1,0,32'h28));
        tbl.push_back(v(0,0,3,0,0, -1,0,32'h28));
        tbl.push_back(v(0,0,2,32'h3F,0, -1,0,32'h3C));
        tbl.push_back(v(0,0,0,0,0, 15,1,32'h40));
        tbl.push_back(v(1,0,0,0,0, -1,0,32'd0));
        tbl.push_back(v(0,0,0,0,0,  0,1,32'd4));
        tbl.push_back(v(0,0,0,0,0,  1,1,32'd8));

        foreach (tbl[i]) begin
            i_reset = tbl[i].rst; i_loading = tbl[i].ld; i_select = tbl[i].sel;
            i_pc_branch = tbl[i].tgt; i_pc_jump = tbl[i].tgt; i_stall = tbl[i].stall;
            i_address = 32'h7C; i_instruccion = 32'hDEADBEEF;
            step();
            chk($sformatf("v%0d.valid", i), 32'(o_valid), tbl[i].ek >= 0 ? 32'd1 : 32'd0);
            chk($sformatf("v%0d.instr", i), o_instruccion, tbl[i].ek >= 0 ? m[tbl[i].ek] : 32'd0);
            chk($sformatf("v%0d.pcinc", i), o_pc_incr, tbl[i].ek >= 0 ? 32'(4 * tbl[i].ek + 4) : 32'd0);
            chk($sformatf("v%0d.count", i), 32'(o_count), 32'(tbl[i].ecount));
            chk($sformatf("v%0d.pc", i), o_pc, tbl[i].epc);
            chk($sformatf("v%0d.halted", i), 32'(o_halted), 0);
        end
        i_reset = 1'b0; i_loading = 1'b0;

        i_select = 2'b10; i_pc_jump = 32'hFFFFFFFF; i_stall = 1'b0;
        step();
        chk("wrap.jpc", o_pc, 32'hFFFFFFFC);
        chk("wrap.jvalid", 32'(o_valid), 0);
        i_select = 2'b00;
        step();
        chk("wrap.instr", o_instruccion, 32'hCAFEF00D);
        chk("wrap.pcinc", o_pc_incr, 32'h0);
        chk("wrap.pc", o_pc, 32'h0);

`ifdef FETCH_HALT_DETECT_EN
        load(32'h8, 32'hFFFFFFFF);
        i_reset = 1'b1;
        step();
        i_reset = 1'b0; i_stall = 1'b1; i_select = 2'b00;
        step(); step(); step();
        chk("halt.flag", 32'(o_halted), 1);
        chk("halt.pc", o_pc, 32'hC);
        chk("halt.count", 32'(o_count), 3);
        step();
        chk("halt.pc_held", o_pc, 32'hC);
        chk("halt.count_held", 32'(o_count), 3);
        i_stall = 1'b0;
        step();
        chk("halt.d1", o_pc_incr, 32'h8);
        step();
        chk("halt.d2", o_instruccion, 32'hFFFFFFFF);
        step();
        chk("halt.empty", 32'(o_valid), 0);
        chk("halt.pc_end", o_pc, 32'hC);
        i_select = 2'b10; i_pc_jump = 32'h0;
        step();
        chk("halt.clear", 32'(o_halted), 0);
        chk("halt.jpc", o_pc, 32'h0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
